// File: rtl/magnetron_cmd_fsm.sv
// magnetron_cmd_fsm: synchronizes and debounces the front-panel buttons,
// synchronizes the door switch and the timer-done flag, and runs the cooking
// state machine that issues one-cycle set/reset pulses to the magnetron latch.
module magnetron_cmd_fsm #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic       S,
    output logic       R,
    output logic [1:0] state
);

    localparam int unsigned NBTN  = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STOP  = 1;
    localparam int unsigned BTN_CLEAR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOK  = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  btn_s1;
    logic [NBTN-1:0]  btn_s2;
    logic [NBTN-1:0]  btn_db;
    logic [NBTN-1:0]  btn_db_d;
    logic [NBTN-1:0]  btn_press;
    logic [CNT_W-1:0] btn_cnt [NBTN];
    logic             door_s1;
    logic             door_s2;
    logic             timer_s1;
    logic             timer_s2;

    state_t state_q;
    state_t state_next;
    logic   s_next;
    logic   r_next;

    logic start_press;
    logic stop_press;
    logic clear_press;
    logic can_start;

    assign btn_raw = {clearn, stopn, startn};

    // Two-flop synchronizers; reset to the idle level of each input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1   <= '1;
            btn_s2   <= '1;
            door_s1  <= 1'b0;
            door_s2  <= 1'b0;
            timer_s1 <= 1'b0;
            timer_s2 <= 1'b0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            door_s1  <= door_closed;
            door_s2  <= door_s1;
            timer_s1 <= timer_done;
            timer_s2 <= timer_s1;
        end
    end

    // Debounce: accept a new level after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db <= '1;
            for (int i = 0; i < NBTN; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (btn_s2[i] != btn_db[i]) begin
                    if (btn_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                        btn_db[i]  <= btn_s2[i];
                        btn_cnt[i] <= '0;
                    end else begin
                        btn_cnt[i] <= btn_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    btn_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press pulse on a debounced 1->0 transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_d  <= '1;
            btn_press <= '0;
        end else begin
            btn_db_d  <= btn_db;
            btn_press <= btn_db_d & ~btn_db;
        end
    end

    assign start_press = btn_press[BTN_START];
    assign stop_press  = btn_press[BTN_STOP];
    assign clear_press = btn_press[BTN_CLEAR];
    assign can_start   = start_press & door_s2 & ~timer_s2;

    // State and latch-drive registers; R is held high through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            S       <= 1'b0;
            R       <= 1'b1;
        end else begin
            state_q <= state_next;
            S       <= s_next;
            R       <= r_next;
        end
    end

    // Next-state and pulse decode, first matching condition wins.
    always_comb begin
        state_next = state_q;
        s_next     = 1'b0;
        r_next     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (stop_press) begin
                    state_next = ST_IDLE;
                end else if (can_start) begin
                    state_next = ST_COOK;
                    s_next     = 1'b1;
                end
            end
            ST_COOK: begin
                if (!door_s2) begin
                    state_next = ST_PAUSE;
                    r_next     = 1'b1;
                end else if (timer_s2) begin
                    state_next = ST_IDLE;
                    r_next     = 1'b1;
                end else if (stop_press) begin
                    state_next = ST_PAUSE;
                    r_next     = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (clear_press) begin
                    state_next = ST_IDLE;
                end else if (can_start) begin
                    state_next = ST_COOK;
                    s_next     = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_magnetron_cmd_fsm.sv
// Directed bench for magnetron_cmd_fsm with hand-computed edge latencies.
module tb_magnetron_cmd_fsm;

    logic       clk;
    logic       reset;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       timer_done;
    logic       S;
    logic       R;
    logic [1:0] state;

    int n_total;
    int n_bad;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] COOK  = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    magnetron_cmd_fsm #(.DB_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .S           (S),
        .R           (R),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then sample 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance n edges, checking S, R and state after each one.
    task automatic hold(input int n, input string tag, input logic s_exp,
                        input logic r_exp, input logic [1:0] st_exp);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk({tag, "_S"}, 32'(S), 32'(s_exp));
            chk({tag, "_R"}, 32'(R), 32'(r_exp));
            chk({tag, "_state"}, 32'(state), 32'(st_exp));
        end
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        startn      = 1'b1;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        timer_done  = 1'b0;

        // Reset values
        step(2);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_R", 32'(R), 32'd1);
        chk("rst_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        step(1);
        chk("rst_rel_R", 32'(R), 32'd0);
        step(3);

        // Start latency: S one cycle after edge 8, then hold to 20 cycles
        startn = 1'b0;
        hold(7, "start_wait", 1'b0, 1'b0, IDLE);
        step(1);
        chk("start_S", 32'(S), 32'd1);
        chk("start_state", 32'(state), 32'(COOK));
        chk("start_R", 32'(R), 32'd0);
        hold(12, "start_held", 1'b0, 1'b0, COOK);
        startn = 1'b1;
        hold(8, "start_rel", 1'b0, 1'b0, COOK);

        // Door opens while cooking: PAUSED and R pulse after edge 3
        door_closed = 1'b0;
        hold(2, "door_wait", 1'b0, 1'b0, COOK);
        step(1);
        chk("door_state", 32'(state), 32'(PAUSE));
        chk("door_R", 32'(R), 32'd1);
        step(1);
        chk("door_R_fall", 32'(R), 32'd0);
        // Start with door open is ignored
        startn = 1'b0;
        hold(10, "door_open_start", 1'b0, 1'b0, PAUSE);
        startn = 1'b1;
        hold(8, "door_open_rel", 1'b0, 1'b0, PAUSE);

        // Resume from PAUSED with door closed
        door_closed = 1'b1;
        step(3);
        startn = 1'b0;
        hold(7, "resume_wait", 1'b0, 1'b0, PAUSE);
        step(1);
        chk("resume_S", 32'(S), 32'd1);
        chk("resume_state", 32'(state), 32'(COOK));
        startn = 1'b1;
        hold(8, "resume_rel", 1'b0, 1'b0, COOK);

        // timer_done and stop together: timer path, single R pulse
        timer_done = 1'b1;
        stopn      = 1'b0;
        hold(2, "timer_wait", 1'b0, 1'b0, COOK);
        step(1);
        chk("timer_state", 32'(state), 32'(IDLE));
        chk("timer_R", 32'(R), 32'd1);
        hold(8, "timer_after", 1'b0, 1'b0, IDLE);
        timer_done = 1'b0;
        stopn      = 1'b1;
        hold(8, "timer_rel", 1'b0, 1'b0, IDLE);

        // Cook then stop to reach PAUSED
        startn = 1'b0;
        step(8);
        chk("cook2_state", 32'(state), 32'(COOK));
        startn = 1'b1;
        step(8);
        stopn = 1'b0;
        hold(7, "stop_wait", 1'b0, 1'b0, COOK);
        step(1);
        chk("stop_state", 32'(state), 32'(PAUSE));
        chk("stop_R", 32'(R), 32'd1);
        stopn = 1'b1;
        hold(8, "stop_rel", 1'b0, 1'b0, PAUSE);

        // Start and clear together in PAUSED: clear wins, no S
        startn = 1'b0;
        clearn = 1'b0;
        hold(7, "clr_wait", 1'b0, 1'b0, PAUSE);
        hold(5, "clr_done", 1'b0, 1'b0, IDLE);
        startn = 1'b1;
        clearn = 1'b1;
        hold(8, "clr_rel", 1'b0, 1'b0, IDLE);

        // Bounce: 3 low / 3 high, five times, never accepted
        for (int k = 0; k < 5; k++) begin
            startn = 1'b0;
            hold(3, "bounce_lo", 1'b0, 1'b0, IDLE);
            startn = 1'b1;
            hold(3, "bounce_hi", 1'b0, 1'b0, IDLE);
        end
        hold(6, "bounce_settle", 1'b0, 1'b0, IDLE);

        // Reset while cooking
        startn = 1'b0;
        step(8);
        chk("cook3_state", 32'(state), 32'(COOK));
        step(3);
        reset = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 32'(IDLE));
        chk("midrst_R", 32'(R), 32'd1);
        chk("midrst_S", 32'(S), 32'd0);
        startn = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        chk("midrst_rel_R", 32'(R), 32'd0);
        hold(10, "midrst_after", 1'b0, 1'b0, IDLE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
